// File: rtl/ext_pipe.sv
// Registered immediate extender: sx/zx/high/shifted modes, illegal-op flag, 1-cycle latency.
// Two-entry skid (M drives outputs, S absorbs one extra); in_ready = !S.valid, straight from a flop.
module ext_pipe #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int SHIFT  = 2,
   parameter int TAG_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IMM_W-1:0]  imm,
   input  logic [2:0]        EOp,
   input  logic [TAG_W-1:0]  tag_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ext,
   output logic [TAG_W-1:0]  tag_out,
   output logic              illegal,
   output logic              err_sticky
);

   typedef struct packed {
      logic [DATA_W-1:0] ext;
      logic [TAG_W-1:0]  tag;
      logic              ill;
   } ent_t;

   ent_t              in_ent;
   ent_t              m_q;
   ent_t              s_q;
   logic              m_vld;
   logic              s_vld;
   logic              acc;
   logic              m_free;
   logic [DATA_W-1:0] sx;
   logic [DATA_W-1:0] zx;

   assign sx = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign zx = {{(DATA_W-IMM_W){1'b0}}, imm};

   always_comb begin
      in_ent     = '0;
      in_ent.tag = tag_in;
      unique case (EOp)
         3'b000:  in_ent.ext = sx;
         3'b001:  in_ent.ext = zx;
         3'b010:  in_ent.ext = {imm, {(DATA_W-IMM_W){1'b0}}};
         3'b011:  in_ent.ext = sx << SHIFT;
         3'b100:  in_ent.ext = zx << SHIFT;
         default: in_ent.ill = 1'b1;
      endcase
   end

   assign acc    = in_valid & in_ready;
   assign m_free = ~m_vld | out_ready;

   // S is only ever occupied while M is, so M refills from S before taking new data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_vld      <= 1'b0;
         s_vld      <= 1'b0;
         m_q        <= '0;
         s_q        <= '0;
         err_sticky <= 1'b0;
      end else begin
         if (flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
         end else if (m_free) begin
            if (s_vld) begin
               m_q   <= s_q;
               m_vld <= 1'b1;
               s_vld <= acc;
               if (acc) s_q <= in_ent;
            end else begin
               m_vld <= acc;
               if (acc) m_q <= in_ent;
            end
         end else if (acc) begin
            s_vld <= 1'b1;
            s_q   <= in_ent;
         end
         if (!flush && acc && in_ent.ill) err_sticky <= 1'b1;
      end
   end

   assign in_ready  = ~s_vld;
   assign out_valid = m_vld;
   assign ext       = m_q.ext;
   assign tag_out   = m_q.tag;
   assign illegal   = m_q.ill;

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, registered immediate extender for the pipelined datapath. It sits between decode and execute. Each accepted request carries an immediate, an extension opcode and a tag (normally the PC). The block returns the extended DATA_W-bit value and the same tag through a valid/ready output with a 2-entry skid buffer, so `in_ready` is always a register output. It adds shifted-zero extension, illegal-opcode detection, flush and back-pressure.

## Interface
- IMM_W, 16, immediate width; must satisfy 1 ≤ IMM_W < DATA_W
- DATA_W, 32, result width
- SHIFT, 2, left-shift amount for the shifted modes; must satisfy 0 ≤ SHIFT < DATA_W
- TAG_W, 32, sideband tag width
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- imm  input  IMM_W  immediate
- EOp  input  3  extension opcode
- tag_in  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- ext  output  DATA_W  extended result
- tag_out  output  TAG_W  tag of the result
- illegal  output  1  the current result came from an undefined EOp
- err_sticky  output  1  set by any accepted illegal EOp; cleared only by reset

## Operation
- EOp decode. "sx" means sign-extend to DATA_W; "zx" means zero-extend to DATA_W.
  - 000: sx(imm).
  - 001: zx(imm).
  - 010: imm placed in bits [DATA_W-1 : DATA_W-IMM_W], with zeros below.
  - 011: sx(imm) << SHIFT.
  - 100: zx(imm) << SHIFT.
  - 101–111: illegal. The result is 0, `illegal` is 1 and `err_sticky` is set.
- All shifts are logical left shifts truncated to DATA_W bits; nothing wraps.
- Extension is combinational on the input side. The result is registered together with `tag_in` and `illegal`.
- Storage is two entries: a main register M (drives the outputs) and a skid register S.
- Accept: `in_valid & in_ready`.
- Drain: `out_valid & out_ready`.
- `in_ready` = !S.valid, registered.
- Per-cycle update:
  - M empty or draining, no accept: M takes S if S is valid, otherwise M becomes empty.
  - M empty or draining, with accept: if S is valid, M takes S and S takes the new entry. Otherwise M takes the new entry.
  - M holds and is not draining, with accept: S takes the new entry.
- Results always come out in acceptance order. Nothing is dropped or duplicated.
- `flush` clears the valid bits of M and S in that cycle and overrides any accept or drain in the same cycle. Data is not required to be cleared. `err_sticky` is not affected.
- Outputs are stable while `out_valid & !out_ready`. The consumer may rely on this.

## Timing
- Reset (reset_n low, asynchronous): `out_valid`=0, `in_ready`=1, `ext`=0, `tag_out`=0, `illegal`=0, `err_sticky`=0, S empty.
- Reset release takes effect on the next rising edge of `clk`.
- Latency is 1 cycle. A request accepted at edge k shows on the outputs after edge k if M was empty or draining.
- Throughput is 1 result per cycle while `out_ready` is held at 1.
- With `out_ready`=0, the block accepts 2 entries. `in_ready` goes low on the edge after the second accept.
- When `out_ready` rises with S full:
  - At the next edge, M takes S and `in_ready` returns to 1.
  - An accept in that same cycle is legal only if `in_ready` was already 1.
- `reset_n` asserted mid-transfer loses all entries. No partial entry survives.
- `flush` and `in_valid` in the same cycle: the request is dropped. `in_ready` is 1 on the following cycle.

## Test plan
- Mode sweep with imm=16'h8001 and `out_ready`=1, one EOp per cycle in order 000, 001, 010, 011, 100:
  - results 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, 32'h00020004, one per cycle, each after 1 cycle latency, tags matching.
- Illegal op, EOp=3'b110 with imm=16'h1234:
  - `ext`=0 and `illegal`=1 for that result.
  - `err_sticky` goes to 1 and stays 1 through later legal ops and through a flush.
  - `err_sticky` returns to 0 only after reset_n is pulsed.
- Back-pressure with `out_ready`=0, sending tags 1, 2, 3 back to back:
  - tags 1 and 2 accepted; `in_ready`=0 from the next cycle; tag 3 held at the input.
  - Raising `out_ready` delivers 1, 2, 3 in order on consecutive cycles with no bubble after the first.
- Flush with both entries full and `in_valid`=1 in the same cycle:
  - next cycle `out_valid`=0 and `in_ready`=1.
  - the flushed request never appears on the output.
- Async reset mid-stream: drop reset_n between clock edges while S is full.
  - outputs go to their reset values immediately, without waiting for a clock edge.
- Parameter build with IMM_W=12, DATA_W=64, SHIFT=1, imm=12'hFFF:
  - EOp 000 gives 64'hFFFF_FFFF_FFFF_FFFF.
  - EOp 100 gives 64'h0000_0000_0000_1FFE.
  - EOp 010 gives 64'hFFF0_0000_0000_0000.
